muldiv_ctrl: RTL and testbench

// - Sequencer and owner of the architectural HI/LO register pair for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// - Emulates fixed multi-cycle latency: MULT* takes MULT_CYCLES, DIV* takes DIV_CYCLES.
// - Raises busy so the hazard unit can stall MFHI/MFLO and further md instructions.
// - Sits beside the ALU in EX; the HI/LO outputs feed the MFHI/MFLO writeback mux.

---
 rtl/md_pkg.sv | 23 ++
 rtl/md_compute.sv | 93 +++++++++
 rtl/muldiv_ctrl.sv | 155 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
//   - md_op_e     : 2-bit operation encoding carried on the op port
//   - md_state_e  : sequencer states
//   - *_DEF       : default width and latency constants
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_e;

    localparam int MD_WIDTH_DEF       = 32;
    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_compute.sv
// Combinational result datapath for MULT/MULTU/DIV/DIVU.
// Owns every signed/unsigned and overflow rule so the sequencer stays simple.
//   op          in   operation (md_op_e)
//   a_q, b_q    in   latched operands (a = dividend, b = divisor for DIV*)
//   res_hi      out  HI result (product high half or remainder)
//   res_lo      out  LO result (product low half or quotient)
//   div_by_zero out  set for DIV/DIVU with b_q == 0 (result must be discarded)
module md_compute
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH_DEF
) (
    input  md_op_e             op,
    input  logic [WIDTH-1:0]   a_q,
    input  logic [WIDTH-1:0]   b_q,
    output logic [WIDTH-1:0]   res_hi,
    output logic [WIDTH-1:0]   res_lo,
    output logic               div_by_zero
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    logic [2*WIDTH-1:0] a_ext_s;
    logic [2*WIDTH-1:0] b_ext_s;
    logic [2*WIDTH-1:0] prod_s;
    logic               signed_div_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic               b_zero_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH-1:0]   b_safe_s;
    logic [WIDTH-1:0]   quo_mag_s;
    logic [WIDTH-1:0]   rem_mag_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    // Multiply: sign-extend to 2*WIDTH for MULT so one unsigned multiplier serves both.
    always_comb begin
        if (op == MD_MULT) begin
            a_ext_s = {{WIDTH{a_q[WIDTH-1]}}, a_q};
            b_ext_s = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        end else begin
            a_ext_s = {ZERO, a_q};
            b_ext_s = {ZERO, b_q};
        end
        prod_s = a_ext_s * b_ext_s;
    end

    // Divide on magnitudes, then restore signs. The most negative dividend over -1
    // falls out naturally: magnitude 2^(W-1), quotient negated back to itself, remainder 0.
    always_comb begin
        signed_div_s = (op == MD_DIV);
        a_neg_s      = signed_div_s & a_q[WIDTH-1];
        b_neg_s      = signed_div_s & b_q[WIDTH-1];
        a_mag_s      = a_neg_s ? (~a_q + ONE) : a_q;
        b_mag_s      = b_neg_s ? (~b_q + ONE) : b_q;
        b_zero_s     = (b_q == ZERO);
        // Divide by one instead of zero; the result is discarded anyway.
        b_safe_s     = b_zero_s ? ONE : b_mag_s;
        quo_mag_s    = a_mag_s / b_safe_s;
        rem_mag_s    = a_mag_s % b_safe_s;
        quo_s        = (a_neg_s ^ b_neg_s) ? (~quo_mag_s + ONE) : quo_mag_s;
        // Remainder takes the sign of the dividend.
        rem_s        = a_neg_s ? (~rem_mag_s + ONE) : rem_mag_s;
    end

    // Result select per operation.
    always_comb begin
        res_hi      = prod_s[2*WIDTH-1:WIDTH];
        res_lo      = prod_s[WIDTH-1:0];
        div_by_zero = 1'b0;
        case (op)
            MD_MULT, MD_MULTU: begin
                res_hi      = prod_s[2*WIDTH-1:WIDTH];
                res_lo      = prod_s[WIDTH-1:0];
                div_by_zero = 1'b0;
            end
            MD_DIV, MD_DIVU: begin
                res_hi      = rem_s;
                res_lo      = quo_s;
                div_by_zero = b_zero_s;
            end
            default: begin
                res_hi      = ZERO;
                res_lo      = ZERO;
                div_by_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer. Owns the architectural HI/LO pair, emulates
// fixed multi-cycle latency and flags busy for hazard stalling.
//   clk, reset_n     clock (rising edge), asynchronous active-low reset
//   start, op, a, b  launch MULT/MULTU/DIV/DIVU (sampled in IDLE only)
//   we_hi, we_lo     MTHI/MTLO write enables with data wdata (IDLE only)
//   busy             operation in flight (N cycles)
//   done             one-cycle pulse in the cycle HI/LO show the result
//   hi, lo           architectural HI/LO registers
module muldiv_ctrl
    import md_pkg::*;
#(
    parameter int WIDTH       = MD_WIDTH_DEF,
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               we_hi,
    input  logic               we_lo,
    input  logic [WIDTH-1:0]   wdata,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    md_op_e             op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    md_op_e             op_in_s;
    logic               latch_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;
    logic               div_by_zero_s;

    assign op_in_s = md_op_e'(op);

    md_compute #(
        .WIDTH (WIDTH)
    ) u_compute (
        .op          (op_q),
        .a_q         (a_q),
        .b_q         (b_q),
        .res_hi      (res_hi_s),
        .res_lo      (res_lo_s),
        .div_by_zero (div_by_zero_s)
    );

    // Next-state, counter and HI/LO update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        latch_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A launch takes priority over a same-cycle MTHI/MTLO.
                    state_d = S_BUSY;
                    latch_s = 1'b1;
                    if ((op_in_s == MD_DIV) || (op_in_s == MD_DIVU)) begin
                        cnt_d = CNT_DIV;
                    end else begin
                        cnt_d = CNT_MULT;
                    end
                end else begin
                    if (we_hi) begin
                        hi_d = wdata;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (we_lo) begin
                        lo_d = wdata;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                    done_d  = 1'b1;
                    // Divide by zero still completes but leaves HI/LO untouched.
                    if (!div_by_zero_s) begin
                        hi_d = res_hi_s;
                        lo_d = res_lo_s;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, HI/LO, done and operand latch registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            done_q  <= 1'b0;
            op_q    <= MD_MULT;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            if (latch_s) begin
                op_q <= op_in_s;
                a_q  <= a;
                b_q  <= b;
            end else begin
                op_q <= op_q;
                a_q  <= a_q;
                b_q  <= b_q;
            end
        end
    end

    assign busy = (state_q == S_BUSY);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: scoreboard of expected HI/LO/latency
// pushed at launch, popped when done is seen.
module tb_muldiv_ctrl;

    localparam int W  = 32;
    localparam int NM = 5;
    localparam int ND = 10;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         we_hi;
    logic         we_lo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cycles;
    } exp_t;

    exp_t         sb[$];
    int           pass_cnt  = 0;
    int           total_cnt = 0;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic [W-1:0] obs_hi;
    logic [W-1:0] obs_lo;
    int           obs_cycles;
    bit           obs_to;

    muldiv_ctrl #(
        .WIDTH       (W),
        .MULT_CYCLES (NM),
        .DIV_CYCLES  (ND)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .we_hi   (we_hi),
        .we_lo   (we_lo),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    // Reference model: returns {hi, lo} after the op, given current HI/LO.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic [W-1:0] ch,
                                          input logic [W-1:0] cl);
        longint       sx;
        longint       sy;
        longint       q;
        longint       rm;
        logic [63:0]  r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = {ch, cl};
        case (o)
            2'd0: r = sx * sy;
            2'd1: r = {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y != 32'd0) begin
                    q  = sx / sy;
                    rm = sx % sy;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            default: begin
                if (y != 32'd0) r = {x % y, x / y};
            end
        endcase
        return r;
    endfunction

    task automatic push(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        logic [63:0] r;
        r        = model(o, x, y, m_hi, m_lo);
        e.hi     = r[63:32];
        e.lo     = r[31:0];
        e.cycles = o[1] ? ND : NM;
        sb.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    // Drive one start pulse; returns at the first busy cycle.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        push(o, x, y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = ~x;
        b     = ~y;
    endtask

    // Count busy cycles until done (bounded); captures hi/lo in the done cycle.
    task automatic collect();
        obs_cycles = 0;
        obs_to     = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (busy === 1'b1) obs_cycles++;
            if (done === 1'b1) begin
                obs_to = 1'b0;
                obs_hi = hi;
                obs_lo = lo;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic set_hilo(input logic [W-1:0] vh, input logic [W-1:0] vl);
        @(negedge clk);
        we_hi = 1'b1;
        wdata = vh;
        @(negedge clk);
        we_hi = 1'b0;
        we_lo = 1'b1;
        wdata = vl;
        @(negedge clk);
        we_lo = 1'b0;
        m_hi  = vh;
        m_lo  = vl;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {busy, done}); else pass_cnt++;
        total_cnt++; if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_hi    = 32'd0;
        m_lo    = 32'd0;
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        we_hi = 1'b1;
        wdata = 32'h12345678;
        @(negedge clk);
        we_hi = 1'b0;
        total_cnt++; if (hi !== 32'h12345678) $display("FAIL mthi: got %h expected 12345678", hi); else pass_cnt++;
        we_lo = 1'b1;
        wdata = 32'h9ABCDEF0;
        @(negedge clk);
        we_lo = 1'b0;
        total_cnt++; if (lo !== 32'h9ABCDEF0) $display("FAIL mtlo: got %h expected 9abcdef0", lo); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mt_busy: got %b expected 0", busy); else pass_cnt++;
        we_hi = 1'b1;
        we_lo = 1'b1;
        wdata = 32'hCAFEF00D;
        @(negedge clk);
        we_hi = 1'b0;
        we_lo = 1'b0;
        total_cnt++; if ({hi, lo} !== {32'hCAFEF00D, 32'hCAFEF00D}) $display("FAIL mt_both: got %h expected cafef00dcafef00d", {hi, lo}); else pass_cnt++;
        m_hi = 32'hCAFEF00D;
        m_lo = 32'hCAFEF00D;
    endtask

    task automatic test_arith();
        logic [1:0]   ops [5];
        logic [W-1:0] as  [5];
        logic [W-1:0] bs  [5];
        logic [1:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        exp_t         e;
        ops = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
        as  = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'd7, 32'h80000000};
        bs  = '{32'd3, 32'd3, 32'd2, 32'd2, 32'hFFFFFFFF};
        for (int i = 0; i < 9; i++) begin
            if (i < 5) begin
                o = ops[i]; x = as[i]; y = bs[i];
            end else begin
                o = 2'($urandom_range(0, 3)); x = $urandom; y = $urandom;
            end
            launch(o, x, y);
            collect();
            e = sb.pop_front();
            total_cnt++; if (obs_to || obs_cycles != e.cycles) $display("FAIL arith%0d_latency: got %0d (timeout %0d) expected %0d", i, obs_cycles, obs_to, e.cycles); else pass_cnt++;
            total_cnt++; if (obs_hi !== e.hi) $display("FAIL arith%0d_hi: op %0d a %h b %h got %h expected %h", i, o, x, y, obs_hi, e.hi); else pass_cnt++;
            total_cnt++; if (obs_lo !== e.lo) $display("FAIL arith%0d_lo: op %0d a %h b %h got %h expected %h", i, o, x, y, obs_lo, e.lo); else pass_cnt++;
            @(negedge clk);
            total_cnt++; if (done !== 1'b0) $display("FAIL arith%0d_done_width: got %b expected 0", i, done); else pass_cnt++;
        end
    endtask

    task automatic test_div_zero();
        exp_t e;
        set_hilo(32'd5, 32'd6);
        // Start together with MTHI/MTLO: the writes must be dropped.
        @(negedge clk);
        push(2'd3, 32'd77, 32'd0);
        start = 1'b1; op = 2'd3; a = 32'd77; b = 32'd0;
        we_hi = 1'b1; we_lo = 1'b1; wdata = 32'hBADBAD00;
        @(negedge clk);
        start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
        collect();
        e = sb.pop_front();
        total_cnt++; if (obs_to || obs_cycles != ND) $display("FAIL divzero_latency: got %0d (timeout %0d) expected %0d", obs_cycles, obs_to, ND); else pass_cnt++;
        total_cnt++; if ({obs_hi, obs_lo} !== {e.hi, e.lo}) $display("FAIL divzero_hilo: got %h expected %h", {obs_hi, obs_lo}, {e.hi, e.lo}); else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        launch(2'd0, 32'd1234, 32'hFFFFFF00);
        @(negedge clk);
        start = 1'b1; op = 2'd3; a = 32'd9; b = 32'd3;
        we_hi = 1'b1; wdata = 32'hFFFF0000;
        @(negedge clk);
        start = 1'b0; we_hi = 1'b0;
        collect();
        e = sb.pop_front();
        total_cnt++; if (obs_to || obs_cycles != e.cycles - 2) $display("FAIL busy_latency: got %0d (timeout %0d) expected %0d", obs_cycles, obs_to, e.cycles - 2); else pass_cnt++;
        total_cnt++; if ({obs_hi, obs_lo} !== {e.hi, e.lo}) $display("FAIL busy_result: got %h expected %h", {obs_hi, obs_lo}, {e.hi, e.lo}); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL busy_no_relaunch: got %b expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        launch(2'd1, 32'hDEADBEEF, 32'h00010001);
        repeat (NM - 1) @(negedge clk);
        // MTLO on the completing edge loses to the result write.
        we_lo = 1'b1; wdata = 32'h5A5A5A5A;
        @(negedge clk);
        we_lo = 1'b0;
        e = sb.pop_front();
        total_cnt++; if (done !== 1'b1) $display("FAIL b2b_done: got %b expected 1", done); else pass_cnt++;
        total_cnt++; if ({hi, lo} !== {e.hi, e.lo}) $display("FAIL b2b_first: got %h expected %h", {hi, lo}, {e.hi, e.lo}); else pass_cnt++;
        // Launch in the done cycle itself.
        push(2'd2, 32'hFFFFFF9C, 32'd7);
        start = 1'b1; op = 2'd2; a = 32'hFFFFFF9C; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        collect();
        e = sb.pop_front();
        total_cnt++; if (obs_to || obs_cycles != ND) $display("FAIL b2b_latency: got %0d (timeout %0d) expected %0d", obs_cycles, obs_to, ND); else pass_cnt++;
        total_cnt++; if ({obs_hi, obs_lo} !== {e.hi, e.lo}) $display("FAIL b2b_second: got %h expected %h", {obs_hi, obs_lo}, {e.hi, e.lo}); else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        bit   saw_done;
        exp_t e;
        set_hilo(32'h11111111, 32'h22222222);
        launch(2'd2, 32'd100, 32'd7);
        e = sb.pop_back();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if ({hi, lo} !== 64'd0) $display("FAIL rst_mid_hilo: got %h expected 0", {hi, lo}); else pass_cnt++;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < ND + 4; i++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        total_cnt++; if (saw_done) $display("FAIL rst_mid_no_done: got activity 1 expected 0"); else pass_cnt++;
        total_cnt++; if ({hi, lo} !== 64'd0) $display("FAIL rst_mid_hold: got %h expected 0", {hi, lo}); else pass_cnt++;
    endtask

    task automatic test_after_reset();
        exp_t e;
        launch(2'd0, 32'h7FFFFFFF, 32'h80000001);
        collect();
        e = sb.pop_front();
        total_cnt++; if (obs_to || obs_cycles != NM) $display("FAIL post_rst_latency: got %0d (timeout %0d) expected %0d", obs_cycles, obs_to, NM); else pass_cnt++;
        total_cnt++; if ({obs_hi, obs_lo} !== {e.hi, e.lo}) $display("FAIL post_rst_result: got %h expected %h", {obs_hi, obs_lo}, {e.hi, e.lo}); else pass_cnt++;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 2'd0;
        a       = 32'd0;
        b       = 32'd0;
        we_hi   = 1'b0;
        we_lo   = 1'b0;
        wdata   = 32'd0;
        m_hi    = 32'd0;
        m_lo    = 32'd0;
        test_reset();
        test_mthi_mtlo();
        test_arith();
        test_div_zero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_op();
        test_after_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
